pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline.
//  Drives write-enables and flushes for PC, IF/ID, ID/EX and EX/MEM, plus a bubble into MEM/WB.
//  Handles three hazard sources:
//   - multi-cycle data-memory access: freeze FSM, the only state in this block;
//   - load-use hazard: one-cycle stall plus a bubble into ID/EX;
//   - taken branch resolved in EX: flush of IF/ID and ID/EX.
// PARAMETERS
//  MEM_LATENCY  2  cycles a load/store occupies MEM; legal 1..16 (1 = no freeze)
//  REG_W        5  register-specifier width
// PORTS
//  Clk            in   1      pipeline clock, rising edge
//  Reset          in   1      asynchronous, active-high
//  ID_Rs          in   REG_W  rs of instruction in ID
//  ID_Rt          in   REG_W  rt of instruction in ID
//  ID_UsesRt      in   1      ID instruction reads rt
//  IDEX_MemRead   in   1      instruction in EX is a load
//  IDEX_Rt        in   REG_W  destination of that load
//  EX_BranchTaken in   1      branch/jump resolved taken in EX
//  MEM_Access     in   1      load or store present in MEM
//  PC_Write       out  1      PC update enable
//  IFID_Write     out  1      IF/ID load enable
//  IDEX_Write     out  1      ID/EX load enable
//  EXMEM_Write    out  1      EX/MEM load enable
//  IFID_Flush     out  1      clear IF/ID (NOP)
//  IDEX_Flush     out  1      load NOP control into ID/EX
//  MEMWB_Bubble   out  1      clear RegWrite/MemtoReg entering MEM/WB
// BEHAVIOUR
//  Reset and state:
//   - States S_RUN, S_WAIT; wait counter cnt (4b).
//   - Reset -> S_RUN, cnt=0, immediately (async). Reset mid-wait aborts the access wait.
//   - While Reset=1: all *_Write=0; IFID_Flush=IDEX_Flush=MEMWB_Bubble=1.
//  Freeze signal (combinational from state):
//   - In S_RUN: freeze = MEM_Access & (MEM_LATENCY>1).
//   - In S_WAIT: freeze = (cnt!=0).
//  Transitions:
//   - S_RUN, freeze: cnt <= MEM_LATENCY-2, go S_WAIT.
//   - S_WAIT, cnt!=0: cnt <= cnt-1, stay.
//   - S_WAIT, cnt==0: release, go S_RUN. MEM_Access is ignored in this cycle.
//   - Result: one access = MEM_LATENCY cycles in MEM, with freeze for the first MEM_LATENCY-1.
//  Outputs during freeze:
//   - PC_Write=IFID_Write=IDEX_Write=EXMEM_Write=0.
//   - MEMWB_Bubble=1; no flushes.
//   - Load-use and branch inputs are ignored (those stages are held, so the inputs are re-evaluated after release).
//  Taken branch, no freeze:
//   - IFID_Flush=1, IDEX_Flush=1; all writes=1.
//   - Branch has priority over load-use in the same cycle.
//  Load-use, no freeze, no branch:
//   - Condition: IDEX_MemRead & IDEX_Rt!=0 & (IDEX_Rt==ID_Rs | (ID_UsesRt & IDEX_Rt==ID_Rt)).
//   - PC_Write=IFID_Write=0, IDEX_Flush=1; IDEX_Write=EXMEM_Write=1; MEMWB_Bubble=0.
//  Default: all writes=1, all flushes/bubble=0.
//  Priority: Reset > freeze > branch > load-use > default.
//  Back-to-back accesses: the next access is detected in the S_RUN cycle after release, so no cycle is lost.
// CONFIGURATION
//  STALL_COUNTER_EN defined:
//   - Adds output Stall_Cycles (32b).
//   - Increments once per cycle with freeze or load-use stall; saturates at 32'hFFFF_FFFF.
//   - Async clear on Reset.
//  Not defined: port and counter are absent; all other behaviour is identical.
// TESTING
//  T1 reset: Reset=1 mid-S_WAIT -> all writes 0, flushes 1 at once; Reset=0 -> S_RUN, writes 1.
//  T2 latency: MEM_LATENCY=3, MEM_Access=1 for 3 cycles -> freeze on cycles 1-2, EXMEM_Write=1 on cycle 3.
//  T3 no wait: MEM_LATENCY=1, MEM_Access held high -> freeze never asserted, state stays S_RUN.
//  T4 load-use: IDEX_MemRead=1, IDEX_Rt=5, ID_Rs=5 -> PC_Write=0, IFID_Write=0, IDEX_Flush=1 for 1 cycle.
//  T5 load-use guard: IDEX_Rt=0=ID_Rs -> no stall; ID_Rt=5, ID_UsesRt=0 -> no stall.
//  T6 priority: EX_BranchTaken=1 + load-use -> flushes only, PC_Write=1.
//     Same inputs under a freeze -> frozen; branch flush occurs on the release cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-access freeze FSM, load-use stall, branch flush.
// Optional build macro STALL_COUNTER_EN adds a saturating 32-bit Stall_Cycles counter output.
module pipeline_hazard_ctrl #(
  parameter int MEM_LATENCY = 2,
  parameter int REG_W       = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_Rt,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Access,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             EXMEM_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             MEMWB_Bubble
`ifdef STALL_COUNTER_EN
  ,
  output logic [31:0]      Stall_Cycles
`endif
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  localparam bit         HAS_WAIT = (MEM_LATENCY > 1);
  localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(MEM_LATENCY - 2) : 4'd0;

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_cnt;
  logic [3:0] w_nextCnt;
  logic       w_freeze;
  logic       w_loadUse;
  logic       w_branchFlush;
  logic       w_loadUseStall;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // The release cycle of S_WAIT never re-arms, so a following access is caught in S_RUN.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_freeze    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (MEM_Access && HAS_WAIT) begin
          w_freeze    = 1'b1;
          w_nextState = S_WAIT;
          w_nextCnt   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_freeze  = 1'b1;
          w_nextCnt = r_cnt - 4'd1;
        end else begin
          w_nextState = S_RUN;
        end
      end
      default: w_nextState = S_RUN;
    endcase
  end

  assign w_loadUse = IDEX_MemRead && (IDEX_Rt != '0) &&
                     ((IDEX_Rt == ID_Rs) || (ID_UsesRt && (IDEX_Rt == ID_Rt)));

  assign w_branchFlush  = !w_freeze && EX_BranchTaken;
  assign w_loadUseStall = !w_freeze && !EX_BranchTaken && w_loadUse;

  always_comb begin
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Write   = 1'b1;
    EXMEM_Write  = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    MEMWB_Bubble = 1'b0;
    if (Reset) begin
      PC_Write     = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Write   = 1'b0;
      EXMEM_Write  = 1'b0;
      IFID_Flush   = 1'b1;
      IDEX_Flush   = 1'b1;
      MEMWB_Bubble = 1'b1;
    end else if (w_freeze) begin
      PC_Write     = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Write   = 1'b0;
      EXMEM_Write  = 1'b0;
      MEMWB_Bubble = 1'b1;
    end else if (w_branchFlush) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (w_loadUseStall) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Flush = 1'b1;
    end
  end

`ifdef STALL_COUNTER_EN
  logic [31:0] r_stallCycles;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_stallCycles <= 32'd0;
    end else if ((w_freeze || w_loadUseStall) && (r_stallCycles != 32'hFFFF_FFFF)) begin
      r_stallCycles <= r_stallCycles + 32'd1;
    end
  end

  assign Stall_Cycles = r_stallCycles;
`endif

endmodule
